mem_stage: RTL



---
 rtl/mem_stage_if.sv | 26 ++
 rtl/mem_stage.sv | 94 +++++++++
 2 files changed

// File: rtl/mem_stage_if.sv
// Bus between the EX/MEM register and the memory stage, plus the MEM/WB
// results that feed the register file and the forwarding path.
interface mem_stage_if;
    logic [1:0]  Mem_WB;
    logic        read_En;
    logic        write_En;
    logic [31:0] DataAddress;
    logic [31:0] WriteData;
    logic [4:0]  dest;
    logic        RegWrite;
    logic [4:0]  Write_Register;
    logic [31:0] Write_Data;
    logic        misalign;

    // Upstream side: presents the EX/MEM request, observes write-back results.
    modport master (
        output Mem_WB, read_En, write_En, DataAddress, WriteData, dest,
        input  RegWrite, Write_Register, Write_Data, misalign
    );

    // Memory stage side.
    modport slave (
        input  Mem_WB, read_En, write_En, DataAddress, WriteData, dest,
        output RegWrite, Write_Register, Write_Data, misalign
    );
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: word loads/stores against an on-chip data
// memory, MEM/WB pipeline register and write-back result selection.
module mem_stage #(
    parameter int DEPTH_LOG2 = 8
) (
    input  logic        clk,
    input  logic        rst,
    mem_stage_if.slave  bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    // Data memory is never cleared; its contents survive rst.
    logic [31:0] r_mem [0:DEPTH-1];

    logic                  r_regwrite;
    logic                  r_memtoreg;
    logic                  r_misalign;
    logic [4:0]            r_dest;
    logic [31:0]           r_alu;
    logic [31:0]           r_rdata;

    logic [DEPTH_LOG2-1:0] w_idx;
    logic                  w_aligned;
    logic                  w_store;
    logic                  w_access_bad;
    logic [31:0]           w_rdata_next;
    logic [31:0]           w_write_data;

    // Upper address bits are dropped, so addresses wrap modulo DEPTH*4.
    assign w_idx        = bus.DataAddress[DEPTH_LOG2+1:2];
    assign w_aligned    = (bus.DataAddress[1:0] == 2'b00);
    assign w_store      = bus.write_En & w_aligned & ~rst;
    assign w_access_bad = (bus.read_En | bus.write_En) & ~w_aligned;

    // Load data select: memory word for an aligned load, zero otherwise.
    always_comb begin
        w_rdata_next = 32'd0;
        if (bus.read_En && w_aligned) begin
            w_rdata_next = r_mem[w_idx];
        end else begin
            w_rdata_next = 32'd0;
        end
    end

    // Store port; a load on the same edge sees the pre-store word.
    always_ff @(posedge clk) begin
        if (w_store) begin
            r_mem[w_idx] <= bus.WriteData;
        end
    end

    // MEM/WB pipeline register, loaded every non-reset cycle with no stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_regwrite <= 1'b0;
            r_memtoreg <= 1'b0;
            r_dest     <= 5'd0;
            r_alu      <= 32'd0;
            r_rdata    <= 32'd0;
        end else begin
            r_regwrite <= bus.Mem_WB[1];
            r_memtoreg <= bus.Mem_WB[0];
            r_dest     <= bus.dest;
            r_alu      <= bus.DataAddress;
            r_rdata    <= w_rdata_next;
        end
    end

    // Sticky misalignment flag, cleared only by rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_misalign <= 1'b0;
        end else if (w_access_bad) begin
            r_misalign <= 1'b1;
        end else begin
            r_misalign <= r_misalign;
        end
    end

    // Write-back mux driven only by MEM/WB state, so it never follows inputs.
    always_comb begin
        w_write_data = 32'd0;
        if (r_memtoreg) begin
            w_write_data = r_rdata;
        end else begin
            w_write_data = r_alu;
        end
    end

    assign bus.RegWrite       = r_regwrite;
    assign bus.Write_Register = r_dest;
    assign bus.Write_Data     = w_write_data;
    assign bus.misalign       = r_misalign;
endmodule
